// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the byte/half/word memory access controller.
//   op_t    : request opcode (LB..SW)
//   state_t : controller FSM state
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic              RstEnable   = 1'b1;
    localparam logic              WriteEnable = 1'b1;
    localparam logic [DATA_W-1:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    function automatic logic is_load(input op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] lsb);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lsb[0];
            OP_LW, OP_SW:         return (lsb != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane logic.
//   op        : access opcode
//   lsb       : byte address bits [1:0]
//   rword     : word read from RAM
//   wdata     : right-justified store data
//   load_data : extracted, extended load result
//   store_data: read word with the addressed lane(s) replaced
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  lsb,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rword[8*lsb +: 8];
        lane_half = lsb[1] ? rword[31:16] : rword[15:0];
    end

    // Load extraction with sign/zero extension
    always_comb begin
        load_data = ZeroWord;
        case (op)
            OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data = {24'h0, lane_byte};
            OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data = {16'h0, lane_half};
            OP_LW:   load_data = rword;
            default: load_data = ZeroWord;
        endcase
    end

    // Store merge: untouched lanes keep the read value
    always_comb begin
        store_data = rword;
        case (op)
            OP_SB: store_data[8*lsb +: 8] = wdata[7:0];
            OP_SH: begin
                if (lsb[1]) store_data[31:16] = wdata[15:0];
                else        store_data[15:0]  = wdata[15:0];
            end
            OP_SW:   store_data = wdata;
            default: store_data = rword;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sub-word load/store controller in front of a word-wide RAM with
// combinational read. Sub-word stores are read-modify-write.
//   clk, rst            : clock, synchronous active-high reset
//   req_i/op_i/addr_i/wdata_i : request, accepted when idle
//   busy_o, done_o, err_o, rdata_o : status and load result
//   mem_we_o/mem_addr_o/mem_data_o/mem_data_i : RAM port
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    state_t      state, state_nxt;
    op_t         op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] store_word_q;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic        req_mis;

    assign req_mis = is_misaligned(op_t'(op_i), addr_i[1:0]);

    mem_lane_align u_align (
        .op         (op_q),
        .lsb        (addr_q[1:0]),
        .rword      (mem_data_i),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) state <= ST_IDLE;
        else                  state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_i && !req_mis)
                    state_nxt = (op_t'(op_i) == OP_SW) ? ST_WR : ST_RD;
            end
            ST_RD:   state_nxt = is_load(op_q) ? ST_IDLE : ST_WR;
            ST_WR:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; write enable is also killed by reset
    always_comb begin
        busy_o     = (state != ST_IDLE);
        mem_we_o   = ~WriteEnable;
        mem_addr_o = ZeroWord;
        mem_data_o = ZeroWord;
        if (state != ST_IDLE) mem_addr_o = {addr_q[31:2], 2'b00};
        if (state == ST_WR) begin
            mem_we_o   = (rst != RstEnable) ? WriteEnable : ~WriteEnable;
            mem_data_o = store_word_q;
        end
    end

    // Request latch, RMW word, and completion registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            op_q         <= OP_LB;
            addr_q       <= ZeroWord;
            wdata_q      <= ZeroWord;
            store_word_q <= ZeroWord;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= ZeroWord;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        op_q         <= op_t'(op_i);
                        addr_q       <= addr_i;
                        wdata_q      <= wdata_i;
                        store_word_q <= wdata_i;
                        if (req_mis) begin
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= ZeroWord;
                        end
                    end
                end
                ST_RD: begin
                    if (is_load(op_q)) begin
                        rdata_o <= load_data;
                        done_o  <= 1'b1;
                    end else begin
                        store_word_q <= store_data;
                    end
                end
                ST_WR:   done_o <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a word RAM model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:63];

    always #5 clk = ~clk;

    // Word RAM: combinational read, synchronous write
    assign mem_data_i = ram[mem_addr_o[7:2]];
    always @(posedge clk) if (mem_we_o) ram[mem_addr_o[7:2]] <= mem_data_o;

    mem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .op_i       (op_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to done_o, checking latency and results.
    task automatic run_op(input string tag, input op_t op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [31:0] exp_maddr,
                          input int exp_we);
        int we_cnt;
        we_cnt  = 0;
        req_i   = 1'b1;
        op_i    = 3'(op);
        addr_i  = addr;
        wdata_i = wdata;
        tick();
        req_i = 1'b0;
        chk({tag, "_maddr"}, mem_addr_o, exp_maddr);
        for (int k = 1; k <= lat; k++) begin
            if (mem_we_o) we_cnt++;
            if (k < lat) begin
                chk({tag, "_early_done"}, 32'(done_o), 32'd0);
                tick();
            end
        end
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
        chk({tag, "_rdata"}, rdata_o, exp_rdata);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_we_cnt"}, 32'(we_cnt), 32'(exp_we));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        rst = 1'b1; req_i = 1'b0; op_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
        tick();
        tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_mdata", mem_data_o, 32'h0);

        // Request together with reset is discarded
        req_i = 1'b1; op_i = 3'(OP_LW); addr_i = 32'h10;
        tick();
        rst = 1'b0; req_i = 1'b0;
        chk("rstreq_busy", 32'(busy_o), 32'd0);
        tick();
        chk("rstreq_done", 32'(done_o), 32'd0);

        ram[4] = 32'h80FF7F01;
        ram[8] = 32'h11223344;

        run_op("lb",  OP_LB,  32'h12, 32'h0, 2, 1'b0, 32'hFFFFFFFF, 32'h10, 0);
        run_op("lbu", OP_LBU, 32'h12, 32'h0, 2, 1'b0, 32'h000000FF, 32'h10, 0);
        run_op("lh",  OP_LH,  32'h12, 32'h0, 2, 1'b0, 32'hFFFF80FF, 32'h10, 0);
        run_op("lhu", OP_LHU, 32'h12, 32'h0, 2, 1'b0, 32'h000080FF, 32'h10, 0);
        run_op("lw",  OP_LW,  32'h10, 32'h0, 2, 1'b0, 32'h80FF7F01, 32'h10, 0);

        // Sub-word store; rdata holds the last load value
        run_op("sb", OP_SB, 32'h21, 32'h000000AB, 3, 1'b0, 32'h80FF7F01, 32'h20, 1);
        chk("sb_ram", ram[8], 32'h1122AB44);

        // Word store then load issued in the done cycle
        run_op("sw", OP_SW, 32'h30, 32'hDEADBEEF, 2, 1'b0, 32'h80FF7F01, 32'h30, 1);
        run_op("lw_b2b", OP_LW, 32'h30, 32'h0, 2, 1'b0, 32'hDEADBEEF, 32'h30, 0);

        // Misaligned requests
        run_op("lw_mis", OP_LW, 32'h31, 32'h0, 1, 1'b1, 32'h0, 32'h0, 0);
        run_op("sh_mis", OP_SH, 32'h23, 32'h5555, 1, 1'b1, 32'h0, 32'h0, 0);
        chk("sh_mis_ram", ram[8], 32'h1122AB44);
        tick();
        chk("mis_err_clear", 32'(err_o), 32'd0);

        // Request while busy is ignored
        req_i = 1'b1; op_i = 3'(OP_LBU); addr_i = 32'h10;
        tick();
        op_i = 3'(OP_SW); addr_i = 32'h20; wdata_i = 32'h0;
        tick();
        req_i = 1'b0;
        chk("busy_done", 32'(done_o), 32'd1);
        chk("busy_rdata", rdata_o, 32'h00000001);
        tick();
        chk("busy_idle", 32'(busy_o), 32'd0);
        chk("busy_no_done", 32'(done_o), 32'd0);
        chk("busy_ram", ram[8], 32'h1122AB44);

        // Reset during the WR cycle of a halfword store
        req_i = 1'b1; op_i = 3'(OP_SH); addr_i = 32'h22; wdata_i = 32'h5555;
        tick();
        req_i = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rstwr_we", 32'(mem_we_o), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstwr_busy", 32'(busy_o), 32'd0);
        chk("rstwr_done", 32'(done_o), 32'd0);
        chk("rstwr_err", 32'(err_o), 32'd0);
        chk("rstwr_rdata", rdata_o, 32'h0);
        chk("rstwr_we2", 32'(mem_we_o), 32'd0);
        chk("rstwr_maddr", mem_addr_o, 32'h0);
        chk("rstwr_mdata", mem_data_o, 32'h0);
        chk("rstwr_ram", ram[8], 32'h1122AB44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The clock SHALL be `clk`, a single clock domain; all state SHALL update on its rising edge.
REQ-002 The reset SHALL be `rst`, synchronous and active-high (`RstEnable` = 1'b1).
REQ-003 Ports SHALL be (name, direction, width, meaning), each on its own line:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  req_i  in  1  request valid
  op_i  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
  addr_i  in  32  byte address
  wdata_i  in  32  store data, right-justified
  busy_o  out  1  high while the controller is not in IDLE
  done_o  out  1  one-cycle completion pulse
  err_o  out  1  misaligned-request flag, valid with done_o
  rdata_o  out  32  load result, valid with done_o
  mem_we_o  out  1  RAM write enable
  mem_addr_o  out  32  RAM address
  mem_data_o  out  32  RAM write word
  mem_data_i  in  32  RAM read word (combinational read)

Function
REQ-004 A request SHALL be accepted on a rising edge where req_i=1 and busy_o=0; op_i, addr_i and wdata_i SHALL be latched on that edge.
REQ-005 The FSM states SHALL be IDLE, RD and WR; busy_o SHALL equal (state != IDLE).
REQ-006 On acceptance: loads, SB and SH SHALL go to RD; SW SHALL go to WR; a misaligned request SHALL stay in IDLE.
REQ-007 Misaligned SHALL mean: LH, LHU or SH with addr_i[0]=1; LW or SW with addr_i[1:0]!=0.
REQ-008 For a misaligned request, done_o=1, err_o=1 and rdata_o=0 SHALL be asserted in the cycle after acceptance, with no RAM access.
REQ-009 In RD and WR, mem_addr_o SHALL be {latched addr[31:2], 2'b00}; in IDLE it SHALL be 0.
REQ-010 In RD, mem_data_i SHALL be sampled at the end of the cycle.
  - Loads: rdata_o is set from mem_data_i and the FSM goes to IDLE.
  - SB/SH: the merged word is registered and the FSM goes to WR.
REQ-011 Byte order SHALL be little-endian: byte lane k occupies bits [8k+7:8k], k = addr[1:0]; the halfword lane is selected by addr[1].
REQ-012 Load extraction SHALL be:
  - LB: sign-extend the byte.
  - LBU: zero-extend the byte.
  - LH: sign-extend the halfword.
  - LHU: zero-extend the halfword.
  - LW: the full word.
REQ-013 Store merge SHALL be:
  - SB: replace lane byte with wdata_i[7:0].
  - SH: replace lane half with wdata_i[15:0].
  - SW: write wdata_i whole.
  - Other lanes SHALL be preserved from the RD sample.
REQ-014 In WR, mem_we_o SHALL be 1 and mem_data_o SHALL be the store word for exactly one cycle; the FSM then goes to IDLE. Outside WR, mem_we_o=0 and mem_data_o=0.
REQ-015 done_o SHALL pulse for one cycle, in the cycle after the final RD (loads) or WR (stores).
REQ-016 Resulting latencies (done_o relative to the acceptance edge) SHALL be: loads and SW +2 cycles; SB/SH +3 cycles; misaligned +1 cycle.
REQ-017 A new request presented in the done_o cycle SHALL be accepted, since busy_o=0 in that cycle.
REQ-018 rdata_o SHALL hold its last value until the next load or misaligned completion; err_o SHALL be 0 on every non-error completion.
REQ-019 req_i while busy_o=1 SHALL be ignored, with no queuing.

Reset
REQ-020 With rst=1 at an edge, the controller SHALL enter IDLE and clear done_o, err_o, rdata_o and all internal registers; busy_o, mem_we_o, mem_addr_o and mem_data_o then read 0 through REQ-005/009/014.
REQ-021 mem_we_o SHALL be gated by !rst combinationally, so reset asserted during WR produces no RAM write at that edge.
REQ-022 A request presented together with rst=1 SHALL be discarded.

Structure
REQ-023 Op encodings (REQ-003) and state encodings SHALL live in the shared defines.v; the block SHALL use `RstEnable`, `WriteEnable` and `ZeroWord` from it.
REQ-024 Lane extract/merge logic SHALL be one combinational sub-module, mem_lane_align; the FSM and registers SHALL stay in mem_access_ctrl.
REQ-025 The bench SHALL connect mem_access_ctrl to the team's word RAM model.

Verification
REQ-026 Word 0x80FF7F01 preloaded at 0x10, then LB/LBU/LH/LHU at 0x12 and LW at 0x10 -> 0xFFFFFFFF, 0x000000FF, 0xFFFF80FF, 0x000080FF, 0x80FF7F01; each done_o at acceptance+2.
REQ-027 Word 0x11223344 at 0x20, then SB 0x000000AB at 0x21 -> RAM word 0x1122AB44; mem_we_o high exactly one cycle; done_o at acceptance+3.
REQ-028 SW 0xDEADBEEF at 0x30, then LW at 0x30 issued in the done_o cycle -> both accepted back-to-back; rdata_o=0xDEADBEEF.
REQ-029 LW at 0x31 and SH at 0x23 -> done_o=err_o=1 at acceptance+1; mem_we_o never high; RAM unchanged.
REQ-030 SH 0x5555 at 0x22 with rst=1 during the WR cycle -> no write; RAM still 0x1122AB44; all outputs 0 on the following cycle.
